vme_reg_initiator: RTL and testbench
====================================

Name: vme_reg_initiator

Overview:
- Bus initiator that drives the VMERdMem/VMEWrMem strobe interface of the generated register-bank responders.
- Accepts single read/write commands over a valid/ready port and issues exactly one strobe per command.
- Waits for VMERdDone/VMEWrDone, with a bounded timeout, and returns read data plus an error flag over a valid/ready response port.
- Sits between the host-side command logic and one or more generated register banks.

Parameters:
- ADDR_WIDTH, 20, width of cmd_addr and VMEAddr.
- TIMEOUT, 255, max cycles to wait for Done after the strobe cycle; legal range 1..65535.
- ERR_CNT_WIDTH, 16, width of the saturating timeout counter.

Ports:
- Clk  in  1  clock; all logic on rising edge
- Rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  initiator can accept a command
- cmd_we  in  1  1=write, 0=read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  32  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  32  read data (0 for writes and for errors)
- rsp_err  out  1  1=timeout
- err_count  out  ERR_CNT_WIDTH  saturating count of timeouts
- VMEAddr  out  ADDR_WIDTH  address to responder
- VMEWrData  out  32  write data to responder
- VMERdData  in  32  read data from responder
- VMERdMem  out  1  one-cycle read strobe
- VMEWrMem  out  1  one-cycle write strobe
- VMERdDone  in  1  read acknowledge; data valid same cycle
- VMEWrDone  in  1  write acknowledge

Behaviour:
- Reset values:
  - cmd_ready=0 during reset, 1 in the first cycle after it.
  - rsp_valid, rsp_err, VMERdMem, VMEWrMem = 0.
  - rsp_rdata, VMEAddr, VMEWrData, err_count = 0.
  - FSM in IDLE; timeout counter = 0.
- All outputs are registered. cmd_ready is 1 only in IDLE.
- FSM states: IDLE, STROBE, WAIT, RESP.
- IDLE:
  - On cmd_valid&cmd_ready, latch cmd_addr into VMEAddr and cmd_wdata into VMEWrData, store cmd_we, go to STROBE.
  - VMEWrData is latched for reads as well.
- STROBE:
  - Exactly one cycle; VMERdMem or VMEWrMem is high for this cycle only.
  - Timeout counter cleared. Go to WAIT.
- WAIT:
  - Samples only the Done matching the current operation; the other Done is ignored.
  - Done seen on a read: rsp_rdata<=VMERdData, rsp_err<=0.
  - Done seen on a write: rsp_rdata<=0, rsp_err<=0.
  - Done seen: rsp_valid<=1, go to RESP.
  - No Done: counter increments. When counter==TIMEOUT-1 and still no Done: rsp_err<=1, rsp_rdata<=0, rsp_valid<=1, err_count increments (saturates at all-ones), go to RESP.
  - Done in the same cycle as the timeout boundary wins; it is not an error.
- RESP:
  - rsp_valid and rsp_rdata/rsp_err hold stable until rsp_ready=1.
  - On acceptance: rsp_valid<=0, go to IDLE.
  - A Done arriving in RESP or IDLE (late ack after timeout) is ignored.
- Latency:
  - Command accept to strobe: 1 cycle.
  - Responder with 1-cycle Done: rsp_valid 3 cycles after the accept edge.
  - Minimum back-to-back period with rsp_ready tied high: 4 cycles.
- VMEAddr and VMEWrData hold from the IDLE latch until the next accepted command.
- Reset mid-operation: return to IDLE and drop strobes/rsp_valid on the next edge. The in-flight command is lost; no response; err_count cleared.
- Width rule: timeout counter is 16 bits; TIMEOUT=1 means Done must arrive the first WAIT cycle.

Decomposition:
- Shared package vme_init_pkg:
  - FSM state enum (IDLE, STROBE, WAIT, RESP).
  - Constant DATA_WIDTH=32.
  - Response struct {rdata, err}.
- One natural sub-module, vme_init_timeout: loadable counter with clear, enable and expire outputs, parameterised by TIMEOUT.
- The FSM stays in the top.

Test Plan:
- Write: cmd_we=1, addr=0x00000, wdata=0x0000ABCD, against a 1-cycle responder -> exactly one VMEWrMem pulse with VMEWrData=0x0000ABCD; rsp_valid 3 cycles after accept; rsp_err=0, rsp_rdata=0.
- Read after write: read addr 0x00000, responder returns 0x0000ABCD with VMERdDone -> rsp_rdata=0x0000ABCD, rsp_err=0; VMERdMem pulse width 1.
- Timeout: TIMEOUT=8, responder never acks -> rsp_valid with rsp_err=1 and rsp_rdata=0 after 8 WAIT cycles; err_count=1. A VMERdDone injected 2 cycles later is ignored; the next command behaves normally.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid/rsp_rdata stable; cmd_ready=0; no strobes. Release -> IDLE next cycle.
- Boundary: Done on exactly the TIMEOUT-1 cycle -> rsp_err=0. Wrong-direction Done (VMEWrDone during a read) -> ignored, read still waits.
- Reset in WAIT: Rst high 1 cycle -> strobes 0, rsp_valid 0, cmd_ready 1 after release; no response for the aborted command.

Source files
------------

// File: rtl/vme_init_pkg.sv
// Shared types and constants for the VME register-bank initiator.
package vme_init_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } vme_state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
  } vme_rsp_t;

endpackage

// File: rtl/vme_reg_initiator_if.sv
// Command, response and VME strobe signals between host logic, the initiator and a register bank.
interface vme_reg_initiator_if #(
  parameter int ADDR_WIDTH = 20
);

  logic                                 cmd_valid;
  logic                                 cmd_ready;
  logic                                 cmd_we;
  logic [ADDR_WIDTH-1:0]                cmd_addr;
  logic [vme_init_pkg::DATA_WIDTH-1:0]  cmd_wdata;

  logic                                 rsp_valid;
  logic                                 rsp_ready;
  logic [vme_init_pkg::DATA_WIDTH-1:0]  rsp_rdata;
  logic                                 rsp_err;

  logic [ADDR_WIDTH-1:0]                VMEAddr;
  logic [vme_init_pkg::DATA_WIDTH-1:0]  VMEWrData;
  logic [vme_init_pkg::DATA_WIDTH-1:0]  VMERdData;
  logic                                 VMERdMem;
  logic                                 VMEWrMem;
  logic                                 VMERdDone;
  logic                                 VMEWrDone;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output VMEAddr, VMEWrData, VMERdMem, VMEWrMem,
    input  VMERdData, VMERdDone, VMEWrDone
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  VMEAddr, VMEWrData, VMERdMem, VMEWrMem,
    output VMERdData, VMERdDone, VMEWrDone
  );

endinterface

// File: rtl/vme_init_timeout.sv
// Wait-cycle counter for the initiator: cleared on the strobe cycle, counts idle WAIT cycles,
// flags expiry once TIMEOUT-1 cycles have elapsed without an acknowledge.
module vme_init_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LIMIT)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == LIMIT);

endmodule

// File: rtl/vme_reg_initiator.sv
// Single-command initiator for generated register banks: one VMERdMem/VMEWrMem strobe per
// command, bounded wait for the matching Done, registered response with timeout flag.
module vme_reg_initiator
  import vme_init_pkg::*;
#(
  parameter int ADDR_WIDTH    = 20,
  parameter int TIMEOUT       = 255,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     Clk,
  input  logic                     Rst,
  vme_reg_initiator_if.master      bus,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  localparam logic [1:0] S_IDLE   = 2'(IDLE);
  localparam logic [1:0] S_STROBE = 2'(STROBE);
  localparam logic [1:0] S_WAIT   = 2'(WAIT);
  localparam logic [1:0] S_RESP   = 2'(RESP);

  logic [1:0]               state_q,     state_d;
  logic                     we_q,        we_d;
  logic                     cmd_ready_q, cmd_ready_d;
  logic                     rsp_valid_q, rsp_valid_d;
  vme_rsp_t                 rsp_q,       rsp_d;
  logic [ADDR_WIDTH-1:0]    vme_addr_q,  vme_addr_d;
  logic [DATA_WIDTH-1:0]    vme_wdata_q, vme_wdata_d;
  logic                     rd_mem_q,    rd_mem_d;
  logic                     wr_mem_q,    wr_mem_d;
  logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;

  logic timer_clear;
  logic timer_enable;
  logic timer_expire;
  logic accept;
  logic done;

  vme_init_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (Clk),
    .rst    (Rst),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expire (timer_expire)
  );

  assign accept = bus.cmd_valid & cmd_ready_q;
  // Only the acknowledge matching the in-flight direction counts.
  assign done   = we_q ? bus.VMEWrDone : bus.VMERdDone;

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_d        = rsp_q;
    vme_addr_d   = vme_addr_q;
    vme_wdata_d  = vme_wdata_q;
    rd_mem_d     = 1'b0;
    wr_mem_d     = 1'b0;
    err_count_d  = err_count_q;
    timer_clear  = 1'b0;
    timer_enable = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          vme_addr_d  = bus.cmd_addr;
          vme_wdata_d = bus.cmd_wdata;
          we_d        = bus.cmd_we;
          rd_mem_d    = ~bus.cmd_we;
          wr_mem_d    = bus.cmd_we;
          state_d     = S_STROBE;
        end
      end
      S_STROBE: begin
        timer_clear = 1'b1;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        // An acknowledge on the expiry cycle still completes without error.
        if (done) begin
          rsp_d.rdata = we_q ? '0 : bus.VMERdData;
          rsp_d.err   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (timer_expire) begin
          rsp_d.rdata = '0;
          rsp_d.err   = 1'b1;
          rsp_valid_d = 1'b1;
          if (err_count_q != '1) begin
            err_count_d = err_count_q + ERR_CNT_WIDTH'(1);
          end
          state_d     = S_RESP;
        end else begin
          timer_enable = 1'b1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
      vme_addr_q  <= '0;
      vme_wdata_q <= '0;
      rd_mem_q    <= 1'b0;
      wr_mem_q    <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
      vme_addr_q  <= vme_addr_d;
      vme_wdata_q <= vme_wdata_d;
      rd_mem_q    <= rd_mem_d;
      wr_mem_q    <= wr_mem_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_q.rdata;
  assign bus.rsp_err   = rsp_q.err;
  assign bus.VMEAddr   = vme_addr_q;
  assign bus.VMEWrData = vme_wdata_q;
  assign bus.VMERdMem  = rd_mem_q;
  assign bus.VMEWrMem  = wr_mem_q;
  assign err_count     = err_count_q;

endmodule

// File: tb/tb_vme_reg_initiator.sv
// Directed bench for vme_reg_initiator with TIMEOUT=8; the bench plays host and responder,
// driving inputs and sampling outputs on the falling clock edge.
module tb_vme_reg_initiator;

  localparam int AW = 20;
  localparam int TO = 8;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [15:0] err_count;

  int compared   = 0;
  int mismatched = 0;
  int wrPulses   = 0;
  int rdPulses   = 0;
  int pulsesBefore;

  vme_reg_initiator_if #(.ADDR_WIDTH(AW)) vif ();

  vme_reg_initiator #(
    .ADDR_WIDTH    (AW),
    .TIMEOUT       (TO),
    .ERR_CNT_WIDTH (16)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .bus       (vif.master),
    .err_count (err_count)
  );

  always #5 Clk = ~Clk;

  // Strobe pulses seen by the responder, sampled at each rising edge
  always @(posedge Clk) begin
    if (vif.VMEWrMem === 1'b1) wrPulses++;
    if (vif.VMERdMem === 1'b1) rdPulses++;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed no finish expected finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Presents one command for a single cycle; returns at the falling edge of the strobe cycle
  task automatic applyStimulus(input logic we, input logic [AW-1:0] addr, input logic [31:0] wdata);
    checkOutput("cmd_ready before accept", 32'(vif.cmd_ready), 32'd1);
    vif.cmd_valid = 1'b1;
    vif.cmd_we    = we;
    vif.cmd_addr  = addr;
    vif.cmd_wdata = wdata;
    tick();
    vif.cmd_valid = 1'b0;
  endtask

  task automatic runWrite(input logic [AW-1:0] addr, input logic [31:0] wdata);
    int wr0;
    wr0 = wrPulses;
    applyStimulus(1'b1, addr, wdata);
    checkOutput("wr strobe", 32'(vif.VMEWrMem), 32'd1);
    checkOutput("no rd strobe on write", 32'(vif.VMERdMem), 32'd0);
    checkOutput("VMEWrData", vif.VMEWrData, wdata);
    checkOutput("VMEAddr", 32'(vif.VMEAddr), 32'(addr));
    checkOutput("cmd_ready busy", 32'(vif.cmd_ready), 32'd0);
    tick();
    checkOutput("wr strobe width", 32'(vif.VMEWrMem), 32'd0);
    checkOutput("rsp_valid early", 32'(vif.rsp_valid), 32'd0);
    vif.VMEWrDone = 1'b1;
    tick();
    vif.VMEWrDone = 1'b0;
    checkOutput("wr rsp_valid", 32'(vif.rsp_valid), 32'd1);
    checkOutput("wr rsp_err", 32'(vif.rsp_err), 32'd0);
    checkOutput("wr rsp_rdata", vif.rsp_rdata, 32'd0);
    checkOutput("wr pulse count", 32'(wrPulses - wr0), 32'd1);
    tick();
    checkOutput("wr rsp_valid dropped", 32'(vif.rsp_valid), 32'd0);
    checkOutput("wr cmd_ready back", 32'(vif.cmd_ready), 32'd1);
  endtask

  initial begin
    vif.cmd_valid = 1'b0;
    vif.cmd_we    = 1'b0;
    vif.cmd_addr  = '0;
    vif.cmd_wdata = '0;
    vif.rsp_ready = 1'b1;
    vif.VMERdData = '0;
    vif.VMERdDone = 1'b0;
    vif.VMEWrDone = 1'b0;

    // Reset state
    Rst = 1'b1;
    tick();
    tick();
    checkOutput("reset cmd_ready", 32'(vif.cmd_ready), 32'd0);
    checkOutput("reset rsp_valid", 32'(vif.rsp_valid), 32'd0);
    checkOutput("reset rsp_err", 32'(vif.rsp_err), 32'd0);
    checkOutput("reset rsp_rdata", vif.rsp_rdata, 32'd0);
    checkOutput("reset VMERdMem", 32'(vif.VMERdMem), 32'd0);
    checkOutput("reset VMEWrMem", 32'(vif.VMEWrMem), 32'd0);
    checkOutput("reset VMEAddr", 32'(vif.VMEAddr), 32'd0);
    checkOutput("reset VMEWrData", vif.VMEWrData, 32'd0);
    checkOutput("reset err_count", 32'(err_count), 32'd0);
    Rst = 1'b0;
    tick();
    checkOutput("cmd_ready after reset", 32'(vif.cmd_ready), 32'd1);

    $display("[TB] write with one-cycle responder");
    runWrite(20'h00000, 32'h0000ABCD);

    $display("[TB] read after write");
    pulsesBefore = rdPulses;
    applyStimulus(1'b0, 20'h00000, 32'h11112222);
    checkOutput("rd strobe", 32'(vif.VMERdMem), 32'd1);
    checkOutput("no wr strobe on read", 32'(vif.VMEWrMem), 32'd0);
    checkOutput("VMEWrData latched on read", vif.VMEWrData, 32'h11112222);
    tick();
    checkOutput("rd strobe width", 32'(vif.VMERdMem), 32'd0);
    vif.VMERdDone = 1'b1;
    vif.VMERdData = 32'h0000ABCD;
    tick();
    vif.VMERdDone = 1'b0;
    vif.VMERdData = '0;
    checkOutput("rd rsp_valid", 32'(vif.rsp_valid), 32'd1);
    checkOutput("rd rsp_rdata", vif.rsp_rdata, 32'h0000ABCD);
    checkOutput("rd rsp_err", 32'(vif.rsp_err), 32'd0);
    checkOutput("rd pulse count", 32'(rdPulses - pulsesBefore), 32'd1);
    tick();

    $display("[TB] timeout with silent responder");
    applyStimulus(1'b0, 20'h00010, 32'd0);
    repeat (8) tick();
    checkOutput("rsp_valid before expiry", 32'(vif.rsp_valid), 32'd0);
    tick();
    checkOutput("timeout rsp_valid", 32'(vif.rsp_valid), 32'd1);
    checkOutput("timeout rsp_err", 32'(vif.rsp_err), 32'd1);
    checkOutput("timeout rsp_rdata", vif.rsp_rdata, 32'd0);
    checkOutput("timeout err_count", 32'(err_count), 32'd1);
    tick();
    tick();
    vif.VMERdDone = 1'b1;
    vif.VMERdData = 32'hDEADBEEF;
    tick();
    vif.VMERdDone = 1'b0;
    vif.VMERdData = '0;
    checkOutput("late ack rsp_valid", 32'(vif.rsp_valid), 32'd0);
    checkOutput("late ack cmd_ready", 32'(vif.cmd_ready), 32'd1);
    checkOutput("late ack err_count", 32'(err_count), 32'd1);
    runWrite(20'h00020, 32'h12345678);

    $display("[TB] response backpressure");
    vif.rsp_ready = 1'b0;
    applyStimulus(1'b0, 20'h00004, 32'd0);
    tick();
    vif.VMERdDone = 1'b1;
    vif.VMERdData = 32'h5A5A1234;
    tick();
    vif.VMERdDone = 1'b0;
    vif.VMERdData = '0;
    checkOutput("bp rsp_valid", 32'(vif.rsp_valid), 32'd1);
    vif.cmd_valid = 1'b1;
    pulsesBefore = wrPulses + rdPulses;
    repeat (5) begin
      tick();
      checkOutput("bp rsp_valid held", 32'(vif.rsp_valid), 32'd1);
      checkOutput("bp rsp_rdata held", vif.rsp_rdata, 32'h5A5A1234);
      checkOutput("bp cmd_ready low", 32'(vif.cmd_ready), 32'd0);
    end
    checkOutput("bp no strobes", 32'(wrPulses + rdPulses - pulsesBefore), 32'd0);
    vif.cmd_valid = 1'b0;
    vif.rsp_ready = 1'b1;
    tick();
    checkOutput("bp released rsp_valid", 32'(vif.rsp_valid), 32'd0);
    checkOutput("bp released cmd_ready", 32'(vif.cmd_ready), 32'd1);

    $display("[TB] acknowledge on the expiry cycle");
    applyStimulus(1'b0, 20'h00008, 32'd0);
    repeat (8) tick();
    vif.VMERdDone = 1'b1;
    vif.VMERdData = 32'h600DF00D;
    tick();
    vif.VMERdDone = 1'b0;
    vif.VMERdData = '0;
    checkOutput("boundary rsp_valid", 32'(vif.rsp_valid), 32'd1);
    checkOutput("boundary rsp_err", 32'(vif.rsp_err), 32'd0);
    checkOutput("boundary rsp_rdata", vif.rsp_rdata, 32'h600DF00D);
    checkOutput("boundary err_count", 32'(err_count), 32'd1);
    tick();

    $display("[TB] wrong-direction acknowledge");
    applyStimulus(1'b0, 20'h0000C, 32'd0);
    tick();
    vif.VMEWrDone = 1'b1;
    repeat (3) tick();
    checkOutput("wrong dir rsp_valid", 32'(vif.rsp_valid), 32'd0);
    vif.VMEWrDone = 1'b0;
    vif.VMERdDone = 1'b1;
    vif.VMERdData = 32'h0BADCAFE;
    tick();
    vif.VMERdDone = 1'b0;
    vif.VMERdData = '0;
    checkOutput("wrong dir then rd rsp_valid", 32'(vif.rsp_valid), 32'd1);
    checkOutput("wrong dir then rd rsp_rdata", vif.rsp_rdata, 32'h0BADCAFE);
    checkOutput("wrong dir then rd rsp_err", 32'(vif.rsp_err), 32'd0);
    tick();

    $display("[TB] reset while waiting");
    applyStimulus(1'b1, 20'h00030, 32'hFFFF0000);
    tick();
    Rst = 1'b1;
    tick();
    checkOutput("abort VMEWrMem", 32'(vif.VMEWrMem), 32'd0);
    checkOutput("abort rsp_valid", 32'(vif.rsp_valid), 32'd0);
    checkOutput("abort cmd_ready in reset", 32'(vif.cmd_ready), 32'd0);
    checkOutput("abort err_count cleared", 32'(err_count), 32'd0);
    Rst = 1'b0;
    vif.VMEWrDone = 1'b1;
    tick();
    vif.VMEWrDone = 1'b0;
    checkOutput("abort cmd_ready after release", 32'(vif.cmd_ready), 32'd1);
    repeat (3) begin
      tick();
      checkOutput("abort no response", 32'(vif.rsp_valid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
